// File: rtl/clock_step_driver.sv
// clock_step_driver
//
// Produces one-cycle command strobes for a downstream up/down counter,
// either from a free-running prescaler (run mode) or from three debounced
// push buttons. Holding up or down gives a single step, then a first
// auto-repeat after REPEAT_DELAY cycles, then further steps every
// REPEAT_RATE cycles for as long as the button stays held.
//
// Command encoding on {o_up, o_down}:
//   00 none, 10 step up, 01 step down, 11 clear
//
// Ports
//   i_clk       clock, rising edge
//   i_rstn      asynchronous active-low reset
//   i_run       synchronous level, 1 = free-run count-up mode
//   i_btn_up    raw asynchronous button, 1 = pressed
//   i_btn_down  raw asynchronous button, 1 = pressed
//   i_btn_clr   raw asynchronous button, 1 = pressed
//   o_up        registered step strobe (see encoding above)
//   o_down      registered step strobe (see encoding above)
//   o_state     manual FSM state: 0 IDLE, 1 DELAY, 2 REPEAT

module clock_step_driver #(
    parameter int TICK_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_run,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_clr,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_state
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0]  DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0]  RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);

    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;
    localparam int BTN_CLR  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [2:0]        raw;
    logic [2:0]        sync_a;
    logic [2:0]        sync_b;
    logic [2:0]        level;
    logic [2:0]        level_d;
    logic [2:0]        rise;
    logic [DB_W-1:0]   db_cnt [3];

    logic [TICK_W-1:0] presc;
    logic              tick;

    state_t            state;
    state_t            next_state;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic              dir_up;
    logic              dir_up_next;
    logic              step_up;
    logic              step_down;
    logic              hold_idle;
    logic              press_up;
    logic              press_down;
    logic              held_lvl;
    logic              opp_lvl;
    logic              abort;
    logic              cmd_up;
    logic              cmd_down;

    assign raw = {i_btn_clr, i_btn_down, i_btn_up};

    // Two-flop synchronizer for all three raw buttons.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Per-button debouncer: the accepted level flips only after DEBOUNCE_CYC
    // consecutive disagreeing samples; a single agreeing sample restarts the
    // run. level_d keeps the previous accepted level for edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            level   <= '0;
            level_d <= '0;
            for (int b = 0; b < 3; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            level_d <= level;
            for (int b = 0; b < 3; b++) begin
                if (sync_b[b] == level[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db_cnt[b] <= '0;
                    level[b]  <= sync_b[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign rise = level & ~level_d;

    // Free-run prescaler: held at 0 while not running, so the first tick
    // lands TICK_DIV cycles after i_run rises. A clear does not stall it;
    // the tick it collides with is simply lost.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            presc <= '0;
        end else if (!i_run || presc == TICK_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = i_run && (presc == TICK_LAST);

    // Clear and run mode both force the manual FSM back to IDLE.
    assign hold_idle  = rise[BTN_CLR] | i_run;
    assign press_up   = rise[BTN_UP] && !level[BTN_DOWN];
    assign press_down = rise[BTN_DOWN] && !level[BTN_UP];
    assign held_lvl   = dir_up ? level[BTN_UP] : level[BTN_DOWN];
    assign opp_lvl    = dir_up ? level[BTN_DOWN] : level[BTN_UP];
    assign abort      = !held_lvl || opp_lvl;

    // Manual FSM state register together with the repeat timer and the
    // latched step direction.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= S_IDLE;
            timer  <= '0;
            dir_up <= 1'b0;
        end else begin
            state  <= next_state;
            timer  <= timer_next;
            dir_up <= dir_up_next;
        end
    end

    // Manual FSM next-state logic. Release of the latched button or a press
    // of the opposite one outranks a step that falls due in the same cycle.
    always_comb begin
        next_state = state;
        if (hold_idle) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (press_up || press_down) begin
                        next_state = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (abort) begin
                        next_state = S_IDLE;
                    end else if (timer == '0) begin
                        next_state = S_REPEAT;
                    end
                end
                S_REPEAT: begin
                    if (abort) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Manual FSM outputs: step requests, timer reload/decrement and the
    // direction latch. The timer is only decremented while nonzero.
    always_comb begin
        step_up     = 1'b0;
        step_down   = 1'b0;
        timer_next  = timer;
        dir_up_next = dir_up;
        if (hold_idle) begin
            timer_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer_next = '0;
                    if (press_up) begin
                        step_up     = 1'b1;
                        dir_up_next = 1'b1;
                        timer_next  = DELAY_LOAD;
                    end else if (press_down) begin
                        step_down   = 1'b1;
                        dir_up_next = 1'b0;
                        timer_next  = DELAY_LOAD;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (abort) begin
                        timer_next = '0;
                    end else if (timer == '0) begin
                        step_up    = dir_up;
                        step_down  = !dir_up;
                        timer_next = RATE_LOAD;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                default: timer_next = '0;
            endcase
        end
    end

    // Command priority: clear, then run tick, then manual step.
    always_comb begin
        cmd_up   = 1'b0;
        cmd_down = 1'b0;
        if (rise[BTN_CLR]) begin
            cmd_up   = 1'b1;
            cmd_down = 1'b1;
        end else if (i_run) begin
            cmd_up = tick;
        end else begin
            cmd_up   = step_up;
            cmd_down = step_down;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_up   <= 1'b0;
            o_down <= 1'b0;
        end else begin
            o_up   <= cmd_up;
            o_down <= cmd_down;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_clock_step_driver.sv
// tb_clock_step_driver
//
// Self-checking bench for clock_step_driver with small parameters.
// A behavioural model tracks the expected strobes and FSM state every
// cycle; directed segments check strobe counts against hand-derived
// constants, and a random phase exercises mixed button/run traffic.

module tb_clock_step_driver;

    localparam int TICK_DIV     = 4;
    localparam int DEBOUNCE_CYC = 3;
    localparam int REPEAT_DELAY = 10;
    localparam int REPEAT_RATE  = 4;

    logic       clk;
    logic       rstn;
    logic       run;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic       o_up;
    logic       o_down;
    logic [1:0] o_state;

    int compared;
    int mismatched;
    int seg_up;
    int seg_down;
    int seg_clr;

    // Behavioural model: raw-sample history per button (bit k = raw value
    // sampled k edges ago), accepted levels, and an absolute-cycle schedule
    // for the next manual step.
    logic [7:0] m_hist [0:2];
    logic [2:0] m_lvl;
    logic [2:0] m_lvl_d;
    int         m_run_len;
    int         m_dir;
    int         m_due;
    int         m_edge;
    logic       m_rep;
    logic       m_up;
    logic       m_down;
    logic [1:0] m_state;

    typedef struct {
        logic       run;
        logic       up;
        logic       down;
        logic       clr;
        int         len;
        int         exp_up;
        int         exp_down;
        int         exp_clr;
        logic [1:0] exp_state;
    } seg_t;

    seg_t segs [$];
    int   pos [$];
    int   first;
    int   hold_u, hold_d, hold_c, hold_r;
    logic v_u, v_d, v_c, v_r;

    clock_step_driver #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_run      (run),
        .i_btn_up   (btn_up),
        .i_btn_down (btn_down),
        .i_btn_clr  (btn_clr),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = '0;
        end
        m_lvl     = '0;
        m_lvl_d   = '0;
        m_run_len = 0;
        m_dir     = 0;
        m_due     = 0;
        m_rep     = 1'b0;
        m_up      = 1'b0;
        m_down    = 1'b0;
        m_state   = 2'd0;
    endtask

    // One rising edge of the model. raw = {clr, down, up}.
    task automatic model_edge(input logic run_s, input logic [2:0] raw);
        logic [2:0]              rise;
        logic [2:0]              nl;
        logic [DEBOUNCE_CYC-1:0] win;
        logic                    held;
        logic                    opp;
        logic                    su;
        logic                    sd;
        rise = m_lvl & ~m_lvl_d;
        su   = 1'b0;
        sd   = 1'b0;
        m_edge++;
        m_run_len = run_s ? m_run_len + 1 : 0;
        if (rise[2]) begin
            m_dir  = 0;
            m_rep  = 1'b0;
            m_up   = 1'b1;
            m_down = 1'b1;
        end else if (run_s) begin
            m_dir  = 0;
            m_rep  = 1'b0;
            m_up   = ((m_run_len % TICK_DIV) == 0);
            m_down = 1'b0;
        end else begin
            if (m_dir == 0) begin
                if (rise[0] && !m_lvl[1]) begin
                    su = 1'b1; m_dir = 1; m_rep = 1'b0; m_due = m_edge + REPEAT_DELAY;
                end else if (rise[1] && !m_lvl[0]) begin
                    sd = 1'b1; m_dir = 2; m_rep = 1'b0; m_due = m_edge + REPEAT_DELAY;
                end
            end else begin
                held = (m_dir == 1) ? m_lvl[0] : m_lvl[1];
                opp  = (m_dir == 1) ? m_lvl[1] : m_lvl[0];
                if (!held || opp) begin
                    m_dir = 0;
                    m_rep = 1'b0;
                end else if (m_edge == m_due) begin
                    su    = (m_dir == 1);
                    sd    = (m_dir == 2);
                    m_rep = 1'b1;
                    m_due = m_edge + REPEAT_RATE;
                end
            end
            m_up   = su;
            m_down = sd;
        end
        m_state = (m_dir == 0) ? 2'd0 : (m_rep ? 2'd2 : 2'd1);
        nl = m_lvl;
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = {m_hist[b][6:0], raw[b]};
            win = m_hist[b][DEBOUNCE_CYC+1:2];
            if (!m_lvl[b] && (&win)) nl[b] = 1'b1;
            if (m_lvl[b] && !(|win)) nl[b] = 1'b0;
        end
        m_lvl_d = m_lvl;
        m_lvl   = nl;
    endtask

    task automatic checkOutput();
        compared++;
        if ({o_up, o_down, o_state} !== {m_up, m_down, m_state}) begin
            mismatched++;
            $display("[TB] FAIL cycle_check t=%0t: got up=%b down=%b state=%0d, want up=%b down=%b state=%0d",
                     $time, o_up, o_down, o_state, m_up, m_down, m_state);
        end
        if (o_up && !o_down) seg_up++;
        if (!o_up && o_down) seg_down++;
        if (o_up && o_down)  seg_clr++;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drive inputs (called just after a falling edge), advance one rising
    // edge, then compare against the model at the following falling edge.
    task automatic applyStimulus(input logic r, input logic u, input logic d, input logic c);
        run      = r;
        btn_up   = u;
        btn_down = d;
        btn_clr  = c;
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_edge(r, {c, d, u});
        @(negedge clk);
        checkOutput();
    endtask

    task automatic add_seg(input logic r, input logic u, input logic d, input logic c,
                           input int len, input int eu, input int ed, input int ec,
                           input logic [1:0] es);
        seg_t s;
        s.run = r; s.up = u; s.down = d; s.clr = c; s.len = len;
        s.exp_up = eu; s.exp_down = ed; s.exp_clr = ec; s.exp_state = es;
        segs.push_back(s);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        seg_up     = 0;
        seg_down   = 0;
        seg_clr    = 0;
        m_edge     = 0;
        rstn       = 1'b0;
        run        = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_clr    = 1'b0;
        model_reset();

        //        run  up   dn   clr  len ups dns clr state
        add_seg(1'b0, 1'b0, 1'b0, 1'b0,  5, 0, 0, 0, 2'd0);
        add_seg(1'b1, 1'b0, 1'b0, 1'b0, 20, 5, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0,  4, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b1, 1'b0, 1'b0,  2, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b1, 1'b0, 1'b0, 30, 5, 0, 0, 2'd2);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b1, 1'b0,  8, 0, 1, 0, 2'd1);
        add_seg(1'b0, 1'b1, 1'b1, 1'b0, 12, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b1, 1'b0, 12, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0,  8, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b1, 1'b1, 1'b0, 12, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0,  8, 0, 0, 0, 2'd0);
        add_seg(1'b1, 1'b0, 1'b0, 1'b0,  2, 0, 0, 0, 2'd0);
        add_seg(1'b1, 1'b0, 1'b0, 1'b1, 50, 12, 0, 1, 2'd0);
        add_seg(1'b0, 1'b0, 1'b0, 1'b0, 10, 0, 0, 0, 2'd0);
        add_seg(1'b0, 1'b1, 1'b0, 1'b0, 20, 3, 0, 0, 2'd2);

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_up",    int'(o_up),    0);
        check_val("reset_down",  int'(o_down),  0);
        check_val("reset_state", int'(o_state), 0);
        rstn = 1'b1;

        // Directed segments; the last one leaves the FSM in REPEAT with a
        // step strobe showing.
        foreach (segs[s]) begin
            seg_up   = 0;
            seg_down = 0;
            seg_clr  = 0;
            for (int k = 0; k < segs[s].len; k++) begin
                applyStimulus(segs[s].run, segs[s].up, segs[s].down, segs[s].clr);
            end
            check_val($sformatf("seg%0d_up", s),    seg_up,         segs[s].exp_up);
            check_val($sformatf("seg%0d_down", s),  seg_down,       segs[s].exp_down);
            check_val($sformatf("seg%0d_clr", s),   seg_clr,        segs[s].exp_clr);
            check_val($sformatf("seg%0d_state", s), int'(o_state),  int'(segs[s].exp_state));
        end

        // Reset in the middle of REPEAT clears outputs immediately; up held
        // through reset steps only after sync + debounce + one cycle.
        rstn = 1'b0;
        #1;
        check_val("rst_async_up",    int'(o_up),    0);
        check_val("rst_async_down",  int'(o_down),  0);
        check_val("rst_async_state", int'(o_state), 0);
        model_reset();
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        rstn  = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (first == 0 && o_up && !o_down) first = k;
        end
        check_val("rst_release_latency", first, 2 + DEBOUNCE_CYC + 1);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Exact tick positions in run mode.
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (o_up && !o_down) pos.push_back(k);
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("run_tick_count", pos.size(), 5);
        foreach (pos[j]) begin
            check_val($sformatf("run_tick_pos%0d", j), pos[j], TICK_DIV * (j + 1));
        end

        // Random traffic against the model, with one reset pulse.
        hold_u = 0; hold_d = 0; hold_c = 0; hold_r = 0;
        v_u = 1'b0; v_d = 1'b0; v_c = 1'b0; v_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_u == 0) begin
                v_u    = 1'($urandom_range(0, 1));
                hold_u = int'($urandom_range(1, 35));
            end
            if (hold_d == 0) begin
                v_d    = ($urandom_range(0, 2) == 0);
                hold_d = int'($urandom_range(1, 35));
            end
            if (hold_c == 0) begin
                v_c    = ($urandom_range(0, 7) == 0);
                hold_c = int'($urandom_range(1, 20));
            end
            if (hold_r == 0) begin
                v_r    = ($urandom_range(0, 3) == 0);
                hold_r = int'($urandom_range(10, 120));
            end
            if (i == 1500) rstn = 1'b0;
            if (i == 1504) rstn = 1'b1;
            applyStimulus(v_r, v_u, v_d, v_c);
            hold_u--;
            hold_d--;
            hold_c--;
            hold_r--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
